sap_control_sequencer: RTL

Control sequencer for the SAP-BR datapath. It is directly upstream of the ULA and drives its Sub, Not, AL0, AL1 and ALU_out controls together with every other bus and load strobe. A one-hot T-state ring (T1..T6) is decoded against the instruction-register opcode and the Z/C flags to produce one control word per clock.

---
 rtl/sap_control_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-BR control sequencer: one-hot T1..T6 ring decoded against opcode and flags
// into one combinational control word per clock, with a sticky halt at T4.
module sap_control_sequencer #(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         T_STATES    = 6
) (
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [3:0]          OPCODE,
  input  logic                FLAG_Z,
  input  logic                FLAG_C,
  output logic [T_STATES-1:0] T_STATE,
  output logic                HLT,
  output logic                Cp,
  output logic                Ep,
  output logic                Lp,
  output logic                Lm,
  output logic                CE,
  output logic                WE,
  output logic                Li,
  output logic                Ei,
  output logic                La,
  output logic                Ea,
  output logic                Lb,
  output logic                Lo,
  output logic                Lf,
  output logic                Sub,
  output logic                Not,
  output logic                AL0,
  output logic                AL1,
  output logic                ALU_out
);

  typedef enum logic [T_STATES-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hE;

  ring_t state, state_nxt;
  logic  halted;
  logic  halt_hit;

  assign T_STATE  = state;
  assign halt_hit = (state == T4) && (OPCODE == HALT_OPCODE);

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state <= state_nxt;
      if (halt_hit) halted <= 1'b1;
    end
  end

  // Ring advance; a halt (pending or latched) pins the ring at T4.
  always_comb begin
    state_nxt = T1;
    case (state)
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = T5;
      T5:      state_nxt = T6;
      T6:      state_nxt = T1;
      default: state_nxt = T1;
    endcase
    if (halted || halt_hit) state_nxt = T4;
  end

  always_comb begin
    HLT = 1'b0; Cp = 1'b0; Ep = 1'b0; Lp = 1'b0; Lm = 1'b0; CE = 1'b0;
    WE = 1'b0; Li = 1'b0; Ei = 1'b0; La = 1'b0; Ea = 1'b0; Lb = 1'b0;
    Lo = 1'b0; Lf = 1'b0; Sub = 1'b0; Not = 1'b0; AL0 = 1'b0; AL1 = 1'b0;
    ALU_out = 1'b0;
    if (CLR_n) begin
      if (halted) begin
        HLT = 1'b1;
      end else begin
        case (state)
          T1: begin Ep = 1'b1; Lm = 1'b1; end
          T2: Cp = 1'b1;
          T3: begin CE = 1'b1; Li = 1'b1; end
          T4: begin
            if (OPCODE == HALT_OPCODE) begin
              HLT = 1'b1;
            end else begin
              case (OPCODE)
                OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
                  Ei = 1'b1; Lm = 1'b1;
                end
                OP_NOT: begin
                  ALU_out = 1'b1; La = 1'b1; Lf = 1'b1;
                  AL1 = 1'b1; AL0 = 1'b1; Not = 1'b1;
                end
                OP_JMP: begin Ei = 1'b1; Lp = 1'b1; end
                OP_JZ:  begin Ei = FLAG_Z; Lp = FLAG_Z; end
                OP_JC:  begin Ei = FLAG_C; Lp = FLAG_C; end
                OP_OUT: begin Ea = 1'b1; Lo = 1'b1; end
                default: ;
              endcase
            end
          end
          T5: begin
            case (OPCODE)
              OP_LDA: begin CE = 1'b1; La = 1'b1; end
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                CE = 1'b1; Lb = 1'b1;
              end
              OP_STA: begin Ea = 1'b1; WE = 1'b1; end
              default: ;
            endcase
          end
          T6: begin
            case (OPCODE)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                ALU_out = 1'b1; La = 1'b1; Lf = 1'b1;
                Sub = (OPCODE == OP_SUB);
                AL0 = (OPCODE == OP_AND) || (OPCODE == OP_XOR);
                AL1 = (OPCODE == OP_OR)  || (OPCODE == OP_XOR);
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
